des_byte_loader: RTL and testbench
==================================

DES_BYTE_LOADER -- requirements
Module: des_byte_loader

Interface
REQ-001 SHALL have parameter BYTE_MSB_FIRST, default 1: when 1, the first byte accepted fills bits [63:56]; when 0, it fills bits [7:0].
REQ-002 SHALL have parameter COUNT_W, default 16: the width of blk_count.
REQ-003 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 byte_in  input  8  serial key or data byte.
REQ-007 byte_valid  input  1  byte_in is presented this cycle.
REQ-008 byte_is_key  input  1  1 = byte_in is a key byte; 0 = byte_in is a data byte.
REQ-009 mode_in  input  1  direction for the current block: 1 = encrypt, 0 = decrypt.
REQ-010 byte_ready  output  1  the loader accepts byte_in this cycle.
REQ-011 blk_ready  input  1  downstream DES stage consumes the presented block.
REQ-012 blk_valid  output  1  plain_text, cipher_key and encrypt_decrypt are stable and valid.
REQ-013 plain_text  output  64  assembled data block; drives des_top plain_text.
REQ-014 cipher_key  output  64  assembled key; drives des_top cipher_key.
REQ-015 encrypt_decrypt  output  1  latched mode; drives des_top encrypt_decrypt.
REQ-016 blk_count  output  COUNT_W  number of blocks handed off since reset.

Function
REQ-017 SHALL accept a byte only when byte_valid and byte_ready are both 1 in the same cycle.
REQ-018 SHALL implement three states: COLLECT, WAIT_KEY and PRESENT.
REQ-019 byte_ready SHALL be 1 in COLLECT and WAIT_KEY, and SHALL be 0 in PRESENT.
REQ-020 Each accepted key byte SHALL shift into the key register and increment a 3-bit key counter; on wrap 7->0, key_loaded SHALL be set.
REQ-021 Until the new key completes, cipher_key SHALL retain the previous complete key.
REQ-022 Each accepted data byte SHALL shift into the data register and increment a 3-bit data counter.
REQ-023 mode_in SHALL be latched into encrypt_decrypt only when data byte 0 of a block is accepted.
REQ-024 On acceptance of data byte 7 with key_loaded=1, the state SHALL become PRESENT and blk_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-025 On acceptance of data byte 7 with key_loaded=0, the state SHALL become WAIT_KEY.
REQ-026 In WAIT_KEY, data bytes SHALL be accepted but discarded, and key bytes SHALL load normally.
REQ-027 In WAIT_KEY, the state SHALL become PRESENT on the cycle after the key counter wraps.
REQ-028 If key byte 7 and data byte 7 would complete together, key byte 7 takes effect first: the key SHALL complete before the block is presented (one byte per cycle, so these are consecutive cycles).
REQ-029 In PRESENT, blk_valid=1 and plain_text, cipher_key and encrypt_decrypt SHALL hold stable until blk_ready=1.
REQ-030 On blk_valid and blk_ready both 1, the state SHALL become COLLECT, the data counter SHALL clear, blk_count SHALL increment, and blk_valid SHALL be 0 on the next cycle.
REQ-031 blk_count SHALL wrap modulo 2^COUNT_W without saturating.
REQ-032 Key bytes arriving in COLLECT mid-block SHALL be legal and SHALL NOT disturb the data counter.

Reset
REQ-033 While rst=1, the following SHALL all be 0: plain_text, cipher_key, encrypt_decrypt, blk_valid, blk_count, both counters and key_loaded.
REQ-034 While rst=1, byte_ready SHALL be 0 and the state SHALL be COLLECT.
REQ-035 byte_ready SHALL be 1 in the first cycle after rst falls.
REQ-036 rst asserted mid-block or in PRESENT SHALL abandon the partial block and key, with no handoff counted.

Structure
REQ-037 A shared package des_pkg SHALL hold the state enum encoding, the block width (64), the byte width (8) and the bytes-per-block constant (8).
REQ-038 A single sub-module des_shift64 SHALL implement the 64-bit byte-shift register with load-enable and direction per BYTE_MSB_FIRST, instantiated twice (key and data).

Verification
REQ-039 Key 13 34 57 79 9B BC DF F1 then data 01 23 45 67 89 AB CD EF with mode_in=1 and blk_ready=1 -> blk_valid for 1 cycle with plain_text=64'h0123456789ABCDEF and cipher_key=64'h133457799BBCDFF1; des_top output=64'h85E813540F0AB405; blk_count=1.
REQ-040 Eight data bytes with no key, then 8 key bytes -> state WAIT_KEY, blk_valid=0 until the cycle after key byte 7, then blk_valid=1.
REQ-041 Full block presented with blk_ready held 0 for 5 cycles -> blk_valid and all outputs stable for the 5 cycles, byte_ready=0, byte_valid ignored; handoff occurs on the cycle blk_ready=1.
REQ-042 mode_in toggled between data bytes 1-7 after mode_in=0 at byte 0 -> encrypt_decrypt=0 at presentation.
REQ-043 rst pulsed after data byte 4 -> all outputs 0; the next 8 data bytes plus key form a fresh block; blk_count=1 after its handoff.
REQ-044 BYTE_MSB_FIRST=0 with the same stimulus as REQ-039 -> plain_text=64'hEFCDAB8967452301.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants and state encoding for the DES byte loader slice.
// Loads are one byte per cycle; a full block is 8 bytes.
package des_pkg;
  localparam int BLK_W         = 64;
  localparam int BYTE_W        = 8;
  localparam int BYTES_PER_BLK = 8;
  localparam int BCNT_W        = $clog2(BYTES_PER_BLK);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_WAIT_KEY = 2'd1,
    ST_PRESENT  = 2'd2
  } state_t;
endpackage

// File: rtl/des_byte_loader_if.sv
// Byte-in / block-out bundle between a byte source, the loader and the DES core.
// master = byte source and block consumer; slave = the loader itself.
interface des_byte_loader_if #(
  parameter int COUNT_W = 16
);
  import des_pkg::*;

  logic [BYTE_W-1:0]  byte_in;
  logic               byte_valid;
  logic               byte_is_key;
  logic               mode_in;
  logic               byte_ready;
  logic               blk_ready;
  logic               blk_valid;
  logic [BLK_W-1:0]   plain_text;
  logic [BLK_W-1:0]   cipher_key;
  logic               encrypt_decrypt;
  logic [COUNT_W-1:0] blk_count;

  modport master (
    output byte_in, byte_valid, byte_is_key, mode_in, blk_ready,
    input  byte_ready, blk_valid, plain_text, cipher_key, encrypt_decrypt, blk_count
  );

  modport slave (
    input  byte_in, byte_valid, byte_is_key, mode_in, blk_ready,
    output byte_ready, blk_valid, plain_text, cipher_key, encrypt_decrypt, blk_count
  );
endinterface

// File: rtl/des_shift64.sv
// 64-bit byte shift register; q_nxt exposes the value q takes at the next edge.
// Byte order: MSB-first pushes new bytes in at [7:0], LSB-first at [63:56].
module des_shift64
  import des_pkg::*;
#(
  parameter bit BYTE_MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [BYTE_W-1:0] din,
  output logic [BLK_W-1:0]  q,
  output logic [BLK_W-1:0]  q_nxt
);

  always_comb begin
    q_nxt = q;
    if (ld_en) begin
      if (BYTE_MSB_FIRST) q_nxt = {q[BLK_W-BYTE_W-1:0], din};
      else                q_nxt = {din, q[BLK_W-1:BYTE_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/des_byte_loader.sv
// Assembles serial key/data bytes into a 64-bit block + key for the DES core.
// Block valid 1 cycle after the last needed byte; byte_ready drops while a block waits on blk_ready.
module des_byte_loader
  import des_pkg::*;
#(
  parameter bit BYTE_MSB_FIRST = 1'b1,
  parameter int COUNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  des_byte_loader_if.slave io
);

  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_BLK - 1);

  state_t             state, state_nxt;
  logic [BCNT_W-1:0]  key_cnt, data_cnt;
  logic               key_loaded;
  logic [BLK_W-1:0]   key_sr, key_sr_nxt, data_sr, data_nxt_unused;
  logic [BLK_W-1:0]   cipher_key_q;
  logic               mode_q;
  logic [COUNT_W-1:0] blk_count_q;

  logic byte_rdy, acc, key_acc, data_ld, key_wrap, data_last, handoff;

  assign byte_rdy  = !rst && (state != ST_PRESENT);
  assign acc       = io.byte_valid && byte_rdy;
  assign key_acc   = acc && io.byte_is_key;
  // Data bytes arriving in WAIT_KEY are accepted but dropped
  assign data_ld   = acc && !io.byte_is_key && (state == ST_COLLECT);
  assign key_wrap  = key_acc && (key_cnt == LAST_BYTE);
  assign data_last = data_ld && (data_cnt == LAST_BYTE);
  assign handoff   = (state == ST_PRESENT) && io.blk_ready;

  des_shift64 #(.BYTE_MSB_FIRST(BYTE_MSB_FIRST)) u_key_sr (
    .clk   (clk),
    .rst   (rst),
    .ld_en (key_acc),
    .din   (io.byte_in),
    .q     (key_sr),
    .q_nxt (key_sr_nxt)
  );

  des_shift64 #(.BYTE_MSB_FIRST(BYTE_MSB_FIRST)) u_data_sr (
    .clk   (clk),
    .rst   (rst),
    .ld_en (data_ld),
    .din   (io.byte_in),
    .q     (data_sr),
    .q_nxt (data_nxt_unused)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT:  if (data_last) state_nxt = key_loaded ? ST_PRESENT : ST_WAIT_KEY;
      ST_WAIT_KEY: if (key_wrap)  state_nxt = ST_PRESENT;
      ST_PRESENT:  if (io.blk_ready) state_nxt = ST_COLLECT;
      default:     state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_COLLECT;
      key_cnt      <= '0;
      data_cnt     <= '0;
      key_loaded   <= 1'b0;
      cipher_key_q <= '0;
      mode_q       <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      state <= state_nxt;
      if (key_acc) key_cnt <= key_cnt + 1'b1;
      // Completed key replaces the visible key in the same edge as its last byte
      if (key_wrap) begin
        key_loaded   <= 1'b1;
        cipher_key_q <= key_sr_nxt;
      end
      if (handoff)      data_cnt <= '0;
      else if (data_ld) data_cnt <= data_cnt + 1'b1;
      if (data_ld && (data_cnt == '0)) mode_q <= io.mode_in;
      if (handoff) blk_count_q <= blk_count_q + 1'b1;
    end
  end

  assign io.byte_ready      = byte_rdy;
  assign io.blk_valid       = !rst && (state == ST_PRESENT);
  assign io.plain_text      = data_sr;
  assign io.cipher_key      = cipher_key_q;
  assign io.encrypt_decrypt = mode_q;
  assign io.blk_count       = blk_count_q;

endmodule

// File: tb/tb_des_byte_loader.sv
// Drives an MSB-first/16-bit-count and an LSB-first/3-bit-count loader in lockstep
// against a byte-queue reference model.
module tb_des_byte_loader;
  import des_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_byte_loader_if #(.COUNT_W(16)) if_m ();
  des_byte_loader_if #(.COUNT_W(3))  if_l ();

  assign if_l.byte_in     = if_m.byte_in;
  assign if_l.byte_valid  = if_m.byte_valid;
  assign if_l.byte_is_key = if_m.byte_is_key;
  assign if_l.mode_in     = if_m.mode_in;
  assign if_l.blk_ready   = if_m.blk_ready;

  des_byte_loader #(.BYTE_MSB_FIRST(1'b1), .COUNT_W(16)) dut_m (.clk(clk), .rst(rst), .io(if_m.slave));
  des_byte_loader #(.BYTE_MSB_FIRST(1'b0), .COUNT_W(3))  dut_l (.clk(clk), .rst(rst), .io(if_l.slave));

  // Reference model: bytes collected in queues, blocks packed on demand
  logic [7:0]  key_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  key_done[8];
  logic [7:0]  data_done[8];
  bit          have_key, waiting, presenting, exp_mode;
  int unsigned n_blk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] b[8], input bit msb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (msb) r[63-8*i -: 8] = b[i];
      else     r[8*i +: 8]    = b[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    key_q.delete();
    data_q.delete();
    for (int i = 0; i < 8; i++) begin
      key_done[i]  = 8'h00;
      data_done[i] = 8'h00;
    end
    have_key = 0; waiting = 0; presenting = 0; exp_mode = 0; n_blk = 0;
  endtask

  task automatic model_update(input bit v, input bit k, input logic [7:0] b,
                              input bit m, input bit br, input bit r);
    if (r) begin
      model_reset();
    end else if (presenting) begin
      if (br) begin
        presenting = 0;
        n_blk++;
      end
    end else if (v) begin
      if (k) begin
        key_q.push_back(b);
        if (key_q.size() == 8) begin
          for (int i = 0; i < 8; i++) key_done[i] = key_q[i];
          key_q.delete();
          have_key = 1;
          if (waiting) begin
            waiting    = 0;
            presenting = 1;
          end
        end
      end else if (!waiting) begin
        if (data_q.size() == 0) exp_mode = m;
        data_q.push_back(b);
        if (data_q.size() == 8) begin
          for (int i = 0; i < 8; i++) data_done[i] = data_q[i];
          data_q.delete();
          if (have_key) presenting = 1;
          else          waiting    = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input bit r);
    chk("rdy_m", if_m.byte_ready, !r && !presenting);
    chk("rdy_l", if_l.byte_ready, !r && !presenting);
    chk("vld_m", if_m.blk_valid, !r && presenting);
    chk("vld_l", if_l.blk_valid, !r && presenting);
    chk("cnt_m", if_m.blk_count, n_blk % 65536);
    chk("cnt_l", if_l.blk_count, n_blk % 8);
    chk("key_m", if_m.cipher_key, pack(key_done, 1'b1));
    chk("key_l", if_l.cipher_key, pack(key_done, 1'b0));
    chk("mode_m", if_m.encrypt_decrypt, exp_mode);
    chk("mode_l", if_l.encrypt_decrypt, exp_mode);
    if (presenting && !r) begin
      chk("pt_m", if_m.plain_text, pack(data_done, 1'b1));
      chk("pt_l", if_l.plain_text, pack(data_done, 1'b0));
    end
  endtask

  // One clock: drive, check pre-edge outputs, clock, advance model, settle to negedge
  task automatic step(input bit v, input bit k, input logic [7:0] b,
                      input bit m, input bit br, input bit r);
    rst              = r;
    if_m.byte_valid  = v;
    if_m.byte_is_key = k;
    if_m.byte_in     = b;
    if_m.mode_in     = m;
    if_m.blk_ready   = br;
    #1;
    check_outputs(r);
    @(posedge clk);
    model_update(v, k, b, m, br, r);
    @(negedge clk);
  endtask

  task automatic send_key(input logic [63:0] kv);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, kv[63-8*i -: 8], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_data(input logic [63:0] dv, input bit m);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, dv[63-8*i -: 8], m, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pt"},  if_m.plain_text, 64'h0);
    chk({tag, "_key"}, if_m.cipher_key, 64'h0);
    chk({tag, "_ed"},  if_m.encrypt_decrypt, 1'b0);
    chk({tag, "_vld"}, if_m.blk_valid, 1'b0);
    chk({tag, "_cnt"}, if_m.blk_count, 16'h0);
    chk({tag, "_ptl"}, if_l.plain_text, 64'h0);
  endtask

  logic [63:0] snap_pt, snap_key, rnd;

  initial begin
    rst = 1'b1;
    if_m.byte_valid = 1'b0; if_m.byte_is_key = 1'b0; if_m.byte_in = 8'h00;
    if_m.mode_in = 1'b0; if_m.blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk_all_zero("rst");
    chk("rst_rdy", if_m.byte_ready, 1'b0);

    // Known-answer block
    send_key(64'h133457799BBCDFF1);
    send_data(64'h0123456789ABCDEF, 1'b1);
    chk("kat_vld",  if_m.blk_valid, 1'b1);
    chk("kat_pt",   if_m.plain_text, 64'h0123456789ABCDEF);
    chk("kat_key",  if_m.cipher_key, 64'h133457799BBCDFF1);
    chk("kat_ptl",  if_l.plain_text, 64'hEFCDAB8967452301);
    chk("kat_ed",   if_m.encrypt_decrypt, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("kat_cnt",  if_m.blk_count, 16'd1);
    chk("kat_vld0", if_m.blk_valid, 1'b0);

    // Data before key: wait for the key, present the cycle after its last byte
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    rnd = {$urandom, $urandom};
    send_data(rnd, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("wk_vld0", if_m.blk_valid, 1'b0);
    end
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("wk_vld1", if_m.blk_valid, 1'b1);
    chk("wk_pt",   if_m.plain_text, rnd);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure: hold outputs while blk_ready low, bytes ignored
    send_data({$urandom, $urandom}, 1'b1);
    snap_pt  = if_m.plain_text;
    snap_key = if_m.cipher_key;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i[0], 8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_pt",  if_m.plain_text, snap_pt);
      chk("bp_key", if_m.cipher_key, snap_key);
      chk("bp_rdy", if_m.byte_ready, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("bp_cnt", if_m.blk_count, 16'd2);

    // Mode only latched on data byte 0
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), (i == 0) ? 1'b0 : i[0], 1'b0, 1'b0);
    chk("mode_ed", if_m.encrypt_decrypt, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset mid-block discards partial block
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_all_zero("mrst");
    send_key({$urandom, $urandom});
    send_data({$urandom, $urandom}, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("mrst_cnt", if_m.blk_count, 16'd1);

    // Random traffic, including rare resets and 3-bit count wrap on the LSB-first unit
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 599) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
